seq_adder_subtractor: RTL and testbench

Parametrised multi-cycle adder/subtractor for the datapath ALU. It computes A+B or A-B over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, carrying between chunks in a register. It registers the result with carry, signed-overflow, zero and negative flags. A start/busy/done handshake lets the control unit trade latency for a shorter carry chain per cycle.

---
 rtl/seq_adder_subtractor.sv | 136 +++++++++++++
 tb/tb_seq_adder_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_subtractor.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with the inter-chunk carry
// kept in a register, then registers the result with carry/overflow/zero/negative flags.
module seq_adder_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_next;
    logic             last_chunk;
    int               lsb;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        done_d     = 1'b0;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        lsb        = int'(cnt_q) * CHUNK;
        last_chunk = (cnt_q == CW'(N - 1));
        chunk_sum  = {1'b0, a_q[lsb +: CHUNK]} + {1'b0, b_q[lsb +: CHUNK]}
                   + (CHUNK + 1)'(carry_q);
        sum_next   = sum_q;
        sum_next[lsb +: CHUNK] = chunk_sum[CHUNK-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{mode}};
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_next;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk) begin
                    // carry into the MSB is recovered from the MSB sum bit and its operands
                    result_d = sum_next;
                    cout_d   = chunk_sum[CHUNK];
                    ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_next[WIDTH-1]) ^ chunk_sum[CHUNK];
                    zero_d   = (sum_next == '0);
                    neg_d    = sum_next[WIDTH-1];
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign Result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_seq_adder_subtractor.sv
// Scoreboard bench for seq_adder_subtractor: three instances (CHUNK 8, 1, 32) share
// operands; a negedge monitor pops expected {Result, c, v, z, n} on every done pulse.
module tb_seq_adder_subtractor;

    typedef logic [35:0] exp_t; // {Result, carry_out, overflow, zero, negative}

    logic        clk;
    logic        clr;
    logic [2:0]  start_v;
    logic        mode;
    logic [31:0] A, B;
    logic [2:0]  busy_v, done_v, c_v, v_v, z_v, n_v;
    logic [31:0] res_v [3];

    int checks = 0;
    int errors = 0;

    exp_t q0[$], q1[$], q2[$];

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vm [8];
    exp_t        ve [8];
    int          exp_lat [3];

    seq_adder_subtractor #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .clr(clr), .start(start_v[0]), .mode(mode), .A(A), .B(B),
        .busy(busy_v[0]), .done(done_v[0]), .Result(res_v[0]), .carry_out(c_v[0]),
        .overflow(v_v[0]), .zero(z_v[0]), .negative(n_v[0]));

    seq_adder_subtractor #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .clr(clr), .start(start_v[1]), .mode(mode), .A(A), .B(B),
        .busy(busy_v[1]), .done(done_v[1]), .Result(res_v[1]), .carry_out(c_v[1]),
        .overflow(v_v[1]), .zero(z_v[1]), .negative(n_v[1]));

    seq_adder_subtractor #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .clr(clr), .start(start_v[2]), .mode(mode), .A(A), .B(B),
        .busy(busy_v[2]), .done(done_v[2]), .Result(res_v[2]), .carry_out(c_v[2]),
        .overflow(v_v[2]), .zero(z_v[2]), .negative(n_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done_v[d] === 1'b1) begin
                if (qsize(d) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected done: got done=1 expected no pending op", d);
                end else begin
                    e = qpop(d);
                    chk($sformatf("dut%0d result", d), res_v[d], e[35:4]);
                    chk($sformatf("dut%0d flags cvzn", d),
                        {28'd0, c_v[d], v_v[d], z_v[d], n_v[d]}, {28'd0, e[3:0]});
                end
            end
        end
    end

    task automatic push_sel(input logic [2:0] sel, input exp_t e);
        if (sel[0]) q0.push_back(e);
        if (sel[1]) q1.push_back(e);
        if (sel[2]) q2.push_back(e);
    endtask

    task automatic run_vec(input logic [2:0] sel, input int idx, input bit check_busy);
        int lat [3];
        lat = '{0, 0, 0};
        @(negedge clk);
        A = va[idx]; B = vb[idx]; mode = vm[idx]; start_v = sel;
        push_sel(sel, ve[idx]);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start_v = 3'b000;
                A = ~va[idx];
                B = 32'hDEAD_BEEF;
                mode = ~vm[idx];
            end
            if (check_busy && i <= 4) chk("busy during run", {31'd0, busy_v[0]}, 32'd1);
            if (check_busy && i == 5) chk("busy in done cycle", {31'd0, busy_v[0]}, 32'd0);
            for (int d = 0; d < 3; d++)
                if (done_v[d] === 1'b1 && lat[d] == 0) lat[d] = i;
        end
        for (int d = 0; d < 3; d++)
            if (sel[d]) chk($sformatf("dut%0d latency vec%0d", d, idx), lat[d], exp_lat[d]);
    endtask

    initial begin
        // negedges counted after the start edge: done appears N+1 negedges later
        exp_lat = '{5, 33, 2};
        va[0] = 32'd5;          vb[0] = 32'd3;          vm[0] = 1'b0; ve[0] = {32'd8,          4'b0000};
        va[1] = 32'd5;          vb[1] = 32'd5;          vm[1] = 1'b1; ve[1] = {32'd0,          4'b1010};
        va[2] = 32'h7FFF_FFFF;  vb[2] = 32'd1;          vm[2] = 1'b0; ve[2] = {32'h8000_0000,  4'b0101};
        va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd1;          vm[3] = 1'b0; ve[3] = {32'd0,          4'b1010};
        va[4] = 32'd0;          vb[4] = 32'd1;          vm[4] = 1'b1; ve[4] = {32'hFFFF_FFFF,  4'b0001};
        va[5] = 32'h8000_0000;  vb[5] = 32'd1;          vm[5] = 1'b1; ve[5] = {32'h7FFF_FFFF,  4'b1100};
        va[6] = 32'h1234_5678;  vb[6] = 32'h1111_1111;  vm[6] = 1'b0; ve[6] = {32'h2345_6789,  4'b0000};
        va[7] = 32'd3;          vb[7] = 32'd5;          vm[7] = 1'b1; ve[7] = {32'hFFFF_FFFE,  4'b0001};

        clr = 1'b1; start_v = 3'b000; mode = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset busy/done", d), {30'd0, busy_v[d], done_v[d]}, 32'd0);
            chk($sformatf("dut%0d reset result", d), res_v[d], 32'd0);
            chk($sformatf("dut%0d reset flags", d), {28'd0, c_v[d], v_v[d], z_v[d], n_v[d]}, 32'd0);
        end
        clr = 1'b0;

        // all three chunk sizes on every vector
        for (int k = 0; k < 8; k++) run_vec(3'b111, k, k == 0);

        // handshake on the CHUNK=8 instance
        @(negedge clk);
        A = 32'd5; B = 32'd3; mode = 1'b0; start_v = 3'b001;
        q0.push_back({32'd8, 4'b0000});
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i <= 3) begin
                start_v[0] = 1'b1;
                A = 32'h1111_0000 + i; B = 32'h2222; mode = 1'b1;
            end
            if (i == 4) start_v = 3'b000;
            if (i == 5) begin
                chk("handshake done cycle", {31'd0, done_v[0]}, 32'd1);
                chk("handshake busy in done cycle", {31'd0, busy_v[0]}, 32'd0);
                A = 32'd10; B = 32'd4; mode = 1'b1; start_v[0] = 1'b1;
                q0.push_back({32'd6, 4'b1000});
            end
            if (i == 6) begin
                start_v = 3'b000;
                chk("back-to-back accepted", {31'd0, busy_v[0]}, 32'd1);
                A = 32'hFFFF_FFFF; B = 32'h7; mode = 1'b0;
            end
            if (i == 7 || i == 8) begin A = i; B = i * 3; end
            if (i == 9) chk("no early done", {31'd0, done_v[0]}, 32'd0);
            if (i == 10) chk("second done", {31'd0, done_v[0]}, 32'd1);
        end
        chk("scoreboard drained", q0.size(), 32'd0);

        // clr mid-run aborts
        @(negedge clk);
        A = 32'd5; B = 32'd3; mode = 1'b0; start_v = 3'b001;
        @(negedge clk); start_v = 3'b000;
        @(negedge clk); clr = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'd0, busy_v[0]}, 32'd0);
        chk("abort done", {31'd0, done_v[0]}, 32'd0);
        chk("abort result", res_v[0], 32'd0);
        chk("abort flags", {28'd0, c_v[0], v_v[0], z_v[0], n_v[0]}, 32'd0);
        clr = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort result held", res_v[0], 32'd0);

        chk("all queues drained", q0.size() + q1.size() + q2.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
